wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the integer register file; the only driver of its write port (writeEnable, writeAddr, writeData).
- Merges two result sources: single-cycle ALU results (no backpressure, highest priority) and load/long-latency results (valid/ready, buffered in a FIFO).
- Holds a 32-entry pending-destination scoreboard so issue logic can stall on unresolved long-latency destinations.

---
 rtl/wb_arbiter_if.sv | 52 +++++
 rtl/wb_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundles the result sources, scoreboard queries and the
// register-file write port of the writeback arbiter.
//   slave  modport : the arbiter side (consumes results, drives the write port)
//   master modport : the surrounding pipeline / testbench side
// Signals:
//   alu_valid/alu_rd/alu_data          single-cycle result, no backpressure
//   lsu_valid/lsu_ready/lsu_rd/lsu_data long-latency result, valid/ready
//   issue_valid/issue_rd/issue_stall    destination reservation at issue
//   query_addr1/2, pending1/2           operand pending lookups
//   wb_we/wb_addr/wb_data               register-file write port (registered)
//   fifo_count                          long-latency FIFO occupancy
interface wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_stall;
  logic [4:0]      query_addr1;
  logic [4:0]      query_addr2;
  logic            pending1;
  logic            pending2;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [CW-1:0]   fifo_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_valid, issue_rd, query_addr1, query_addr2,
    output lsu_ready, issue_stall, pending1, pending2,
    output wb_we, wb_addr, wb_data, fifo_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_valid, issue_rd, query_addr1, query_addr2,
    input  lsu_ready, issue_stall, pending1, pending2,
    input  wb_we, wb_addr, wb_data, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage in front of the integer register file.
// Merges single-cycle ALU results (highest priority, no backpressure) with
// long-latency results buffered in a DEPTH-entry FIFO, and keeps a 32-bit
// pending-destination scoreboard for the issue stage.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - wb_arbiter_if.slave (result sources, scoreboard, write port)
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      fifo_rd_q   [DEPTH];
  logic [XLEN-1:0] fifo_data_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pend_q, pend_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic lsu_ready;
  logic issue_stall;
  logic alu_wr;
  logic push;
  logic pop;
  logic issue_set;

  // Ready depends only on the registered count, so a pop in the same cycle
  // does not open a slot until the following cycle.
  assign lsu_ready   = (count_q < CW'(DEPTH));
  assign alu_wr      = bus.alu_valid && (bus.alu_rd != 5'd0);
  // A handshake with rd==0 is accepted but dropped: nothing to write back.
  assign push        = bus.lsu_valid && lsu_ready && (bus.lsu_rd != 5'd0);
  assign pop         = !alu_wr && (count_q != '0);
  assign issue_stall = bus.issue_valid && pend_q[bus.issue_rd];
  assign issue_set   = bus.issue_valid && !issue_stall && (bus.issue_rd != 5'd0);

  assign bus.lsu_ready   = lsu_ready;
  assign bus.issue_stall = issue_stall;
  assign bus.pending1    = pend_q[bus.query_addr1];
  assign bus.pending2    = pend_q[bus.query_addr2];
  assign bus.wb_we       = wb_we_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.fifo_count  = count_q;

  always_comb begin
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (alu_wr) begin
      wb_we_d   = 1'b1;
      wb_addr_d = bus.alu_rd;
      wb_data_d = bus.alu_data;
    end else if (pop) begin
      wb_we_d   = 1'b1;
      wb_addr_d = fifo_rd_q[rd_ptr_q];
      wb_data_d = fifo_data_q[rd_ptr_q];
    end
  end

  // Set and clear never target the same bit (issue to a pending register
  // stalls), so their order here is irrelevant for correctness.
  always_comb begin
    pend_d = pend_q;
    if (pop) begin
      pend_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
    end
    if (issue_set) begin
      pend_d[bus.issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Stage boundary: control state, scoreboard and write port register here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pend_q    <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q   <= count_d;
      pend_q    <= pend_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // FIFO storage carries data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= bus.lsu_rd;
      fifo_data_q[wr_ptr_q] <= bus.lsu_data;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic mon_en;

  logic [36:0] exp_q[$];
  logic [36:0] mfifo[$];

  wb_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_ready;
    logic [2:0]  e_cnt;
    logic        e_stall;
    logic        e_p1;
    logic        e_p2;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Write-port monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en && bus.wb_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: got addr %0d data %0h expected none", bus.wb_addr, bus.wb_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({bus.wb_addr, bus.wb_data} !== e) begin
          errors++;
          $display("FAIL sb_write: got addr %0d data %0h expected addr %0d data %0h",
                   bus.wb_addr, bus.wb_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  // One cycle of scoreboard-driven stimulus; a small reference of the
  // arbitration predicts which write the coming edge produces.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      output logic acc);
    logic m_ready;
    int   m_cnt;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lrd;
    bus.lsu_data  = ld;
    m_cnt   = mfifo.size();
    m_ready = (m_cnt < DEPTH);
    acc     = lv && m_ready;
    if (av && ard != 5'd0) exp_q.push_back({ard, ad});
    else if (mfifo.size() != 0) exp_q.push_back(mfifo.pop_front());
    if (acc && lrd != 5'd0) mfifo.push_back({lrd, ld});
    @(negedge clk);
    chk("sb_lsu_ready", {31'd0, bus.lsu_ready}, {31'd0, m_ready});
    chk("sb_fifo_count", {29'd0, bus.fifo_count}, m_cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    logic hv;
    logic [4:0] hrd;
    logic [31:0] hd;
    logic av;
    logic [4:0] ard;
    logic [31:0] ad;

    checks = 0;
    errors = 0;
    mon_en = 1'b0;

    // av ard ad | lv lrd ld | iv ird | q1 q2 | ready cnt stall p1 p2 | we addr data
    tbl[0]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd0,5'd0, 1'b1,3'd0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    tbl[1]  = '{1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd0,5'd0, 1'b1,3'd0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    tbl[2]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd0,5'd0, 1'b1,3'd0,1'b0,1'b0,1'b0, 1'b1,5'd5,32'hDEADBEEF};
    tbl[3]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd0,5'd0, 1'b1,3'd0,1'b0,1'b0,1'b0, 1'b0,5'd5,32'hDEADBEEF};
    tbl[4]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b1,5'd7, 5'd7,5'd0, 1'b1,3'd0,1'b0,1'b0,1'b0, 1'b0,5'd5,32'hDEADBEEF};
    tbl[5]  = '{1'b0,5'd0,32'h0,        1'b1,5'd7,32'h1234, 1'b0,5'd0, 5'd7,5'd7, 1'b1,3'd0,1'b0,1'b1,1'b1, 1'b0,5'd5,32'hDEADBEEF};
    tbl[6]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd7,5'd0, 1'b1,3'd1,1'b0,1'b1,1'b0, 1'b0,5'd5,32'hDEADBEEF};
    tbl[7]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd7,5'd0, 1'b1,3'd0,1'b0,1'b0,1'b0, 1'b1,5'd7,32'h1234};
    tbl[8]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd7,5'd0, 1'b1,3'd0,1'b0,1'b0,1'b0, 1'b0,5'd7,32'h1234};
    tbl[9]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b1,5'd3, 5'd3,5'd0, 1'b1,3'd0,1'b0,1'b0,1'b0, 1'b0,5'd7,32'h1234};
    tbl[10] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b1,5'd3, 5'd3,5'd0, 1'b1,3'd0,1'b1,1'b1,1'b0, 1'b0,5'd7,32'h1234};
    tbl[11] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b1,5'd0, 5'd3,5'd0, 1'b1,3'd0,1'b0,1'b1,1'b0, 1'b0,5'd7,32'h1234};
    tbl[12] = '{1'b1,5'd10,32'hA,       1'b1,5'd9,32'h99,   1'b0,5'd0, 5'd3,5'd9, 1'b1,3'd0,1'b0,1'b1,1'b0, 1'b0,5'd7,32'h1234};
    tbl[13] = '{1'b1,5'd0,32'hBAD,      1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd3,5'd9, 1'b1,3'd1,1'b0,1'b1,1'b0, 1'b1,5'd10,32'hA};
    tbl[14] = '{1'b0,5'd0,32'h0,        1'b1,5'd0,32'h55,   1'b0,5'd0, 5'd3,5'd0, 1'b1,3'd0,1'b0,1'b1,1'b0, 1'b1,5'd9,32'h99};
    tbl[15] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd3,5'd0, 1'b1,3'd0,1'b0,1'b1,1'b0, 1'b0,5'd9,32'h99};
    tbl[16] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd3,5'd0, 1'b1,3'd0,1'b0,1'b1,1'b0, 1'b0,5'd9,32'h99};

    rst             = 1'b1;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = 5'd0;
    bus.alu_data    = 32'h0;
    bus.lsu_valid   = 1'b0;
    bus.lsu_rd      = 5'd0;
    bus.lsu_data    = 32'h0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.query_addr1 = 5'd0;
    bus.query_addr2 = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven directed vectors.
    for (int i = 0; i < 17; i++) begin
      bus.alu_valid   = tbl[i].av;
      bus.alu_rd      = tbl[i].ard;
      bus.alu_data    = tbl[i].ad;
      bus.lsu_valid   = tbl[i].lv;
      bus.lsu_rd      = tbl[i].lrd;
      bus.lsu_data    = tbl[i].ld;
      bus.issue_valid = tbl[i].iv;
      bus.issue_rd    = tbl[i].ird;
      bus.query_addr1 = tbl[i].q1;
      bus.query_addr2 = tbl[i].q2;
      @(negedge clk);
      chk($sformatf("v%0d_lsu_ready", i),   {31'd0, bus.lsu_ready},   {31'd0, tbl[i].e_ready});
      chk($sformatf("v%0d_fifo_count", i),  {29'd0, bus.fifo_count},  {29'd0, tbl[i].e_cnt});
      chk($sformatf("v%0d_issue_stall", i), {31'd0, bus.issue_stall}, {31'd0, tbl[i].e_stall});
      chk($sformatf("v%0d_pending1", i),    {31'd0, bus.pending1},    {31'd0, tbl[i].e_p1});
      chk($sformatf("v%0d_pending2", i),    {31'd0, bus.pending2},    {31'd0, tbl[i].e_p2});
      chk($sformatf("v%0d_wb_we", i),       {31'd0, bus.wb_we},       {31'd0, tbl[i].e_we});
      chk($sformatf("v%0d_wb_addr", i),     {27'd0, bus.wb_addr},     {27'd0, tbl[i].e_addr});
      chk($sformatf("v%0d_wb_data", i),     bus.wb_data,              tbl[i].e_data);
      @(posedge clk);
      #1;
    end
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.query_addr1 = 5'd0;
    bus.query_addr2 = 5'd0;

    // Burst: fill the FIFO while the ALU owns the port, then drain in order.
    mon_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 5'(20 + k), 32'hA000 + 32'(k), 1'b1, 5'(1 + k), 32'hB000 + 32'(k), acc);
      chk($sformatf("burst_acc%0d", k), {31'd0, acc}, 32'd1);
    end
    chk("burst_full_count", {29'd0, bus.fifo_count}, 32'd4);
    chk("burst_full_ready", {31'd0, bus.lsu_ready}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc);
    end
    chk("burst_drained", exp_q.size(), 32'd0);

    // Randomised mix; the source holds its offer until accepted.
    hv  = 1'b0;
    hrd = 5'd0;
    hd  = 32'h0;
    for (int n = 0; n < 300; n++) begin
      if (!hv && $urandom_range(1, 0) == 1) begin
        hv  = 1'b1;
        hrd = 5'($urandom_range(31, 0));
        hd  = $urandom;
      end
      av  = ($urandom_range(2, 0) != 0);
      ard = 5'($urandom_range(31, 0));
      ad  = $urandom;
      step(av, ard, ad, hv, hrd, hd, acc);
      if (acc) hv = 1'b0;
    end
    for (int k = 0; k < 2 * DEPTH + 2; k++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc);
    end
    @(negedge clk);
    #1;
    chk("rand_drained", exp_q.size(), 32'd0);
    chk("rand_count_zero", {29'd0, bus.fifo_count}, 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-operation with a partly full FIFO and pending bits set.
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd11;
    step(1'b1, 5'd21, 32'hC1, 1'b1, 5'd11, 32'hD1, acc);
    bus.issue_rd    = 5'd12;
    step(1'b1, 5'd22, 32'hC2, 1'b1, 5'd12, 32'hD2, acc);
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
    step(1'b1, 5'd23, 32'hC3, 1'b1, 5'd13, 32'hD3, acc);
    bus.alu_valid   = 1'b0;
    bus.lsu_valid   = 1'b0;
    bus.query_addr1 = 5'd11;
    bus.query_addr2 = 5'd12;
    #1;
    chk("pre_rst_count", {29'd0, bus.fifo_count}, 32'd3);
    chk("pre_rst_pending1", {31'd0, bus.pending1}, 32'd1);
    chk("pre_rst_pending2", {31'd0, bus.pending2}, 32'd1);
    mon_en = 1'b0;
    exp_q.delete();
    mfifo.delete();
    rst = 1'b1;
    #1;
    chk("rst_wb_we", {31'd0, bus.wb_we}, 32'd0);
    chk("rst_fifo_count", {29'd0, bus.fifo_count}, 32'd0);
    chk("rst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    chk("rst_pending1", {31'd0, bus.pending1}, 32'd0);
    chk("rst_pending2", {31'd0, bus.pending2}, 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_we%0d", k), {31'd0, bus.wb_we}, 32'd0);
      chk($sformatf("post_rst_cnt%0d", k), {29'd0, bus.fifo_count}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
